// File: rtl/hazard_pkg.sv
// Shared types and constants for the ID-stage hazard scoreboard.
// A slot holds an in-flight instruction's write flag, destination register and load flag.
package hazard_pkg;

  typedef struct packed {
    logic       wr;
    logic [4:0] addr;
    logic       ld;
  } stage_slot_t;

  localparam logic [4:0]  REG_ZERO    = 5'd0;
  localparam stage_slot_t SLOT_BUBBLE = '{wr: 1'b0, addr: 5'd0, ld: 1'b0};

endpackage

// File: rtl/hazard_stage_slot.sv
// One pipeline slot register of the scoreboard.
// The slot holds its value under freeze and can load a bubble instead of its input.
module hazard_stage_slot
  import hazard_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        freeze,
  input  logic        loadBubble,
  input  stage_slot_t slotIn,
  output stage_slot_t slotOut
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slotOut <= SLOT_BUBBLE;
    end else if (!freeze) begin
      slotOut <= loadBubble ? SLOT_BUBBLE : slotIn;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Scoreboard beside the ID stage: tracks EX/MEM/WB producers and raises stalls
// for late branch operands and load-use, with a saturating stall-cycle counter.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             freeze,
  input  logic             issue_valid,
  input  logic             reg_writeD,
  input  logic [4:0]       write_reg_addrD,
  input  logic             mem_to_regD,
  input  logic             branchD,
  input  logic [4:0]       rs_addrD,
  input  logic [4:0]       rt_addrD,
  input  logic             use_rsD,
  input  logic             use_rtD,
  output logic             reg_writeE,
  output logic             reg_writeM,
  output logic             reg_writeW,
  output logic [4:0]       write_reg_addrE,
  output logic [4:0]       write_reg_addrM,
  output logic [4:0]       write_reg_addrW,
  output logic             mem_to_regE,
  output logic             mem_to_regM,
  output logic             stallF,
  output logic             stallD,
  output logic             flushE,
  output logic [CNT_W-1:0] stall_count
);

  stage_slot_t slotD, slotE, slotM, slotW, slotMToW;
  logic        hazard;
  logic        bubbleE;
  logic [CNT_W-1:0] stallCnt;

  function automatic logic liveFor(input stage_slot_t s, input logic [4:0] r);
    return s.wr && (s.addr != REG_ZERO) && (s.addr == r);
  endfunction

  // Branches resolve in ID, so they cannot take an EX result nor a load still in MEM.
  function automatic logic srcHazard(input stage_slot_t e, input stage_slot_t m,
                                     input logic branch, input logic [4:0] r);
    if (branch) return liveFor(e, r) || (liveFor(m, r) && m.ld);
    return liveFor(e, r) && e.ld;
  endfunction

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    hazard = issue_valid &&
             ((use_rsD && srcHazard(slotE, slotM, branchD, rs_addrD)) ||
              (use_rtD && srcHazard(slotE, slotM, branchD, rt_addrD)));
  end

  assign slotD = '{wr:   reg_writeD && (write_reg_addrD != REG_ZERO),
                   addr: write_reg_addrD,
                   ld:   mem_to_regD};
  assign bubbleE = hazard || !issue_valid;

  // WB results always forward, so the load flag has no meaning past MEM.
  assign slotMToW = '{wr: slotM.wr, addr: slotM.addr, ld: 1'b0};

  // ID -> EX
  hazard_stage_slot uSlotE (
    .clk(clk), .rst_n(rst_n), .freeze(freeze), .loadBubble(bubbleE),
    .slotIn(slotD), .slotOut(slotE)
  );

  // EX -> MEM
  hazard_stage_slot uSlotM (
    .clk(clk), .rst_n(rst_n), .freeze(freeze), .loadBubble(1'b0),
    .slotIn(slotE), .slotOut(slotM)
  );

  // MEM -> WB
  hazard_stage_slot uSlotW (
    .clk(clk), .rst_n(rst_n), .freeze(freeze), .loadBubble(1'b0),
    .slotIn(slotMToW), .slotOut(slotW)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCnt <= '0;
    end else if (!freeze && hazard) begin
      stallCnt <= satInc(stallCnt);
    end
  end

  assign stallF          = freeze || hazard;
  assign stallD          = freeze || hazard;
  assign flushE          = hazard && !freeze;
  assign stall_count     = stallCnt;
  assign reg_writeE      = slotE.wr;
  assign reg_writeM      = slotM.wr;
  assign reg_writeW      = slotW.wr;
  assign write_reg_addrE = slotE.addr;
  assign write_reg_addrM = slotM.addr;
  assign write_reg_addrW = slotW.addr;
  assign mem_to_regE     = slotE.ld;
  assign mem_to_regM     = slotM.ld;

endmodule
